// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
package shift_deser_pkg;

  // FSM state encoding
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-order selectors for the MSB_FIRST parameter
  localparam int unsigned LSB_FIRST = 0;
  localparam int unsigned MSB_FIRST = 1;

endpackage

// File: rtl/shift_deser_if.sv
// Serial-in / parallel-out bus of shift_deser.
//   ser_in, ser_en, frame_start : serial bit, strobe, start-of-word qualifier
//   par_out, par_valid, par_ready : parallel word with valid/ready handshake
//   busy, overrun, frame_err      : status (overrun/frame_err sticky)
//   clr_flags                     : clears the sticky status flags
interface shift_deser_if #(
  parameter int unsigned WIDTH = 4
);

  logic             ser_in;
  logic             ser_en;
  logic             frame_start;
  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             par_ready;
  logic             busy;
  logic             overrun;
  logic             frame_err;
  logic             clr_flags;

  // Producer/consumer side (drives serial input, consumes the word)
  modport master (
    output ser_in, ser_en, frame_start, par_ready, clr_flags,
    input  par_out, par_valid, busy, overrun, frame_err
  );

  // Deserializer side
  modport slave (
    input  ser_in, ser_en, frame_start, par_ready, clr_flags,
    output par_out, par_valid, busy, overrun, frame_err
  );

endinterface

// File: rtl/shift_deser_obuf.sv
// Single-entry valid/ready output register.
//   wr_valid/wr_data : completed word offered for storage
//   wr_drop_c        : word offered while the entry is full and not being read
//   rd_valid/rd_data : held word; rd_ready consumes it
// A write is accepted when the entry is empty or is read in the same cycle,
// so words can stream back-to-back with no bubble.
module shift_deser_obuf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_drop_c,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             free_c;
  logic             wr_c;

  // Entry free for a write this cycle
  always_comb begin
    free_c    = !valid_q || rd_ready;
    wr_c      = wr_valid && free_c;
    wr_drop_c = wr_valid && !free_c;
  end

  // Hold register; a read clears valid unless a write refills it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (wr_c) begin
      valid_q <= 1'b1;
      data_q  <= wr_data;
    end else if (valid_q && rd_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign rd_valid = valid_q;
  assign rd_data  = data_q;

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer with framing and a one-word output buffer.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : serial input, parallel valid/ready output, sticky status
// Received bits are stored by arrival index (bit i at sh[i]); the bit order
// is applied only when the completed word is handed to the output buffer.
module shift_deser #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  shift_deser_if.slave bus
);

  import shift_deser_pkg::state_t;
  import shift_deser_pkg::IDLE;
  import shift_deser_pkg::SHIFT;
  import shift_deser_pkg::LSB_FIRST;

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] word_c;
  logic             accept_c;
  logic             done_c;
  logic             ferr_set_c;
  logic             drop_c;
  logic             busy_q;
  logic             overrun_q;
  logic             frame_err_q;
  logic             obuf_valid;
  logic [WIDTH-1:0] obuf_data;

  // State, bit count and shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      busy_q  <= (state_d == SHIFT);
    end
  end

  // Next-state: accept, append or restart the word; detect completion
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    accept_c   = 1'b0;
    done_c     = 1'b0;
    ferr_set_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ser_en && bus.frame_start) begin
          accept_c = 1'b1;
          sh_d     = '0;
          sh_d[0]  = bus.ser_in;
          cnt_d    = CNT_W'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ser_en) begin
          accept_c = 1'b1;
          if (bus.frame_start) begin
            // Restart: the partial word is thrown away
            ferr_set_c = 1'b1;
            sh_d       = '0;
            sh_d[0]    = bus.ser_in;
            cnt_d      = CNT_W'(1);
          end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
              if (cnt_q == CNT_W'(i)) sh_d[i] = bus.ser_in;
            end
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Final bit accepted: hand the word off and return to IDLE
    if (accept_c && (cnt_d == CNT_W'(WIDTH))) begin
      done_c  = 1'b1;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  // Map arrival order onto output bit positions
  always_comb begin
    word_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (MSB_FIRST != LSB_FIRST) word_c[int'(WIDTH) - 1 - i] = sh_d[i];
      else                        word_c[i]                   = sh_d[i];
    end
  end

  // Sticky flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= drop_c     | (overrun_q   & ~bus.clr_flags);
      frame_err_q <= ferr_set_c | (frame_err_q & ~bus.clr_flags);
    end
  end

  shift_deser_obuf #(
    .WIDTH (WIDTH)
  ) u_obuf (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_valid  (done_c),
    .wr_data   (word_c),
    .wr_drop_c (drop_c),
    .rd_ready  (bus.par_ready),
    .rd_valid  (obuf_valid),
    .rd_data   (obuf_data)
  );

  assign bus.par_out   = obuf_data;
  assign bus.par_valid = obuf_valid;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser: MSB-first and LSB-first WIDTH=4 instances
// share one stimulus table; a WIDTH=1 instance and reset are hand-sequenced.
module tb_shift_deser;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  shift_deser_if #(.WIDTH(4)) if_m ();
  shift_deser_if #(.WIDTH(4)) if_l ();
  shift_deser_if #(.WIDTH(1)) if_1 ();

  shift_deser #(.WIDTH(4), .MSB_FIRST(1)) u_msb (.clk(clk), .reset_n(reset_n), .bus(if_m));
  shift_deser #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (.clk(clk), .reset_n(reset_n), .bus(if_l));
  shift_deser #(.WIDTH(1), .MSB_FIRST(1)) u_w1  (.clk(clk), .reset_n(reset_n), .bus(if_1));

  typedef struct {
    logic       en, din, fs, rdy, clr;
    logic       valid, busy, ovr, ferr;
    logic [3:0] out_m, out_l;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(logic en, logic din, logic fs, logic rdy, logic clr,
                             logic valid, logic busy, logic ovr, logic ferr,
                             logic [3:0] out_m, logic [3:0] out_l);
    vec_t r;
    r.en = en; r.din = din; r.fs = fs; r.rdy = rdy; r.clr = clr;
    r.valid = valid; r.busy = busy; r.ovr = ovr; r.ferr = ferr;
    r.out_m = out_m; r.out_l = out_l;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive both WIDTH=4 instances identically
  task automatic drive4(input logic en, input logic din, input logic fs,
                        input logic rdy, input logic clr);
    if_m.ser_en = en; if_m.ser_in = din; if_m.frame_start = fs;
    if_m.par_ready = rdy; if_m.clr_flags = clr;
    if_l.ser_en = en; if_l.ser_in = din; if_l.frame_start = fs;
    if_l.par_ready = rdy; if_l.clr_flags = clr;
  endtask

  task automatic drive1(input logic en, input logic din, input logic fs, input logic rdy);
    if_1.ser_en = en; if_1.ser_in = din; if_1.frame_start = fs;
    if_1.par_ready = rdy; if_1.clr_flags = 1'b0;
  endtask

  task automatic chk_zero4(input string tag);
    chk({tag, " m_out"},   32'(if_m.par_out),   32'h0);
    chk({tag, " m_valid"}, 32'(if_m.par_valid), 32'h0);
    chk({tag, " m_busy"},  32'(if_m.busy),      32'h0);
    chk({tag, " m_ovr"},   32'(if_m.overrun),   32'h0);
    chk({tag, " m_ferr"},  32'(if_m.frame_err), 32'h0);
    chk({tag, " l_out"},   32'(if_l.par_out),   32'h0);
    chk({tag, " l_valid"}, 32'(if_l.par_valid), 32'h0);
  endtask

  task automatic chk1(input string tag, input logic valid, input logic out, input logic ovr);
    chk({tag, " valid"}, 32'(if_1.par_valid), 32'(valid));
    chk({tag, " out"},   32'(if_1.par_out),   32'(out));
    chk({tag, " busy"},  32'(if_1.busy),      32'h0);
    chk({tag, " ovr"},   32'(if_1.overrun),   32'(ovr));
  endtask

  initial begin
    // en din fs rdy clr | valid busy ovr ferr | out_m out_l
    // 1,0,1,1 MSB/LSB first; valid for exactly one cycle
    vecs.push_back(v(1,1,1,1,0, 0,1,0,0, 4'h0,4'h0));
    vecs.push_back(v(1,0,0,1,0, 0,1,0,0, 4'h0,4'h0));
    vecs.push_back(v(1,1,0,1,0, 0,1,0,0, 4'h0,4'h0));
    vecs.push_back(v(1,1,0,1,0, 1,0,0,0, 4'hB,4'hD));
    vecs.push_back(v(0,0,0,1,0, 0,0,0,0, 4'hB,4'hD));
    vecs.push_back(v(1,1,0,1,0, 0,0,0,0, 4'hB,4'hD)); // no frame_start: ignored
    // Continuous stream 3, C, F
    vecs.push_back(v(1,0,1,1,0, 0,1,0,0, 4'hB,4'hD));
    vecs.push_back(v(1,0,0,1,0, 0,1,0,0, 4'hB,4'hD));
    vecs.push_back(v(1,1,0,1,0, 0,1,0,0, 4'hB,4'hD));
    vecs.push_back(v(1,1,0,1,0, 1,0,0,0, 4'h3,4'hC));
    vecs.push_back(v(1,1,1,1,0, 0,1,0,0, 4'h3,4'hC));
    vecs.push_back(v(1,1,0,1,0, 0,1,0,0, 4'h3,4'hC));
    vecs.push_back(v(1,0,0,1,0, 0,1,0,0, 4'h3,4'hC));
    vecs.push_back(v(1,0,0,1,0, 1,0,0,0, 4'hC,4'h3));
    vecs.push_back(v(1,1,1,1,0, 0,1,0,0, 4'hC,4'h3));
    vecs.push_back(v(1,1,0,1,0, 0,1,0,0, 4'hC,4'h3));
    vecs.push_back(v(1,1,0,1,0, 0,1,0,0, 4'hC,4'h3));
    vecs.push_back(v(1,1,0,1,0, 1,0,0,0, 4'hF,4'hF));
    vecs.push_back(v(0,0,0,1,0, 0,0,0,0, 4'hF,4'hF));
    // par_ready low: A held, 5 dropped -> overrun, then cleared
    vecs.push_back(v(1,1,1,0,0, 0,1,0,0, 4'hF,4'hF));
    vecs.push_back(v(1,0,0,0,0, 0,1,0,0, 4'hF,4'hF));
    vecs.push_back(v(1,1,0,0,0, 0,1,0,0, 4'hF,4'hF));
    vecs.push_back(v(1,0,0,0,0, 1,0,0,0, 4'hA,4'h5));
    vecs.push_back(v(1,0,1,0,0, 1,1,0,0, 4'hA,4'h5));
    vecs.push_back(v(1,1,0,0,0, 1,1,0,0, 4'hA,4'h5));
    vecs.push_back(v(1,0,0,0,0, 1,1,0,0, 4'hA,4'h5));
    vecs.push_back(v(1,1,0,0,0, 1,0,1,0, 4'hA,4'h5));
    vecs.push_back(v(0,0,0,0,1, 1,0,0,0, 4'hA,4'h5));
    // Write and read in the same cycle: valid stays high with new data
    vecs.push_back(v(1,0,1,0,0, 1,1,0,0, 4'hA,4'h5));
    vecs.push_back(v(1,0,0,0,0, 1,1,0,0, 4'hA,4'h5));
    vecs.push_back(v(1,1,0,0,0, 1,1,0,0, 4'hA,4'h5));
    vecs.push_back(v(1,0,0,1,0, 1,0,0,0, 4'h2,4'h4));
    vecs.push_back(v(0,0,0,1,0, 0,0,0,0, 4'h2,4'h4));
    // Two bits, then restart with 0,1,1,0; clr_flags loses to the set
    vecs.push_back(v(1,1,1,1,0, 0,1,0,0, 4'h2,4'h4));
    vecs.push_back(v(1,1,0,1,0, 0,1,0,0, 4'h2,4'h4));
    vecs.push_back(v(1,0,1,1,1, 0,1,0,1, 4'h2,4'h4));
    vecs.push_back(v(1,1,0,1,0, 0,1,0,1, 4'h2,4'h4));
    vecs.push_back(v(0,0,0,1,0, 0,1,0,1, 4'h2,4'h4)); // strobe gap holds
    vecs.push_back(v(1,1,0,1,0, 0,1,0,1, 4'h2,4'h4));
    vecs.push_back(v(1,0,0,1,0, 1,0,0,1, 4'h6,4'h6));
    vecs.push_back(v(0,0,0,1,0, 0,0,0,1, 4'h6,4'h6));
    vecs.push_back(v(0,0,0,1,1, 0,0,0,0, 4'h6,4'h6));

    reset_n = 1'b0;
    drive4(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    #12;
    chk_zero4("reset");
    chk1("w1 reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive4(vecs[i].en, vecs[i].din, vecs[i].fs, vecs[i].rdy, vecs[i].clr);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d m_valid", i), 32'(if_m.par_valid), 32'(vecs[i].valid));
      chk($sformatf("row%0d m_out",   i), 32'(if_m.par_out),   32'(vecs[i].out_m));
      chk($sformatf("row%0d m_busy",  i), 32'(if_m.busy),      32'(vecs[i].busy));
      chk($sformatf("row%0d m_ovr",   i), 32'(if_m.overrun),   32'(vecs[i].ovr));
      chk($sformatf("row%0d m_ferr",  i), 32'(if_m.frame_err), 32'(vecs[i].ferr));
      chk($sformatf("row%0d l_valid", i), 32'(if_l.par_valid), 32'(vecs[i].valid));
      chk($sformatf("row%0d l_out",   i), 32'(if_l.par_out),   32'(vecs[i].out_l));
    end

    // Asynchronous reset after three bits of a word
    @(negedge clk); drive4(1, 1, 1, 1, 0);
    @(negedge clk); drive4(1, 0, 0, 1, 0);
    @(negedge clk); drive4(1, 1, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("pre-reset m_busy", 32'(if_m.busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero4("async reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive4(1, 1'(i % 2), 0, 1, 0);
      @(posedge clk);
      #1;
      chk_zero4($sformatf("post-reset bit%0d", i));
    end
    @(negedge clk);
    drive4(0, 0, 0, 0, 0);

    // WIDTH=1: every frame_start bit is a complete word
    @(negedge clk); drive1(1, 1, 1, 1);
    @(posedge clk); #1; chk1("w1 word1", 1'b1, 1'b1, 1'b0);
    @(negedge clk); drive1(1, 0, 1, 1);
    @(posedge clk); #1; chk1("w1 word0", 1'b1, 1'b0, 1'b0);
    @(negedge clk); drive1(1, 1, 0, 1);
    @(posedge clk); #1; chk1("w1 nofs", 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive1(1, 1, 1, 0);
    @(posedge clk); #1; chk1("w1 held", 1'b1, 1'b1, 1'b0);
    @(negedge clk); drive1(1, 0, 1, 0);
    @(posedge clk); #1; chk1("w1 drop", 1'b1, 1'b1, 1'b1);
    @(negedge clk); drive1(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_deser.md
SHIFT_DESER -- requirements
Module: shift_deser

Interface
REQ-001 Parameter WIDTH, default 4, word length in bits; legal range 1..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = first received bit is par_out[WIDTH-1], 0 = first received bit is par_out[0].
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 ser_in  input  1  serial data bit, sampled only when ser_en=1.
REQ-006 ser_en  input  1  bit strobe; one bit is accepted per clk cycle with ser_en=1.
REQ-007 frame_start  input  1  qualifies the bit accepted this cycle as bit 0 of a new word; ignored when ser_en=0.
REQ-008 par_out  output  WIDTH  assembled parallel word; stable while par_valid=1.
REQ-009 par_valid  output  1  par_out holds an unread word.
REQ-010 par_ready  input  1  consumer accepts par_out; transfer occurs on a cycle with par_valid=1 and par_ready=1.
REQ-011 busy  output  1  1 while in SHIFT state.
REQ-012 overrun  output  1  sticky: a completed word was dropped because the output buffer was full.
REQ-013 frame_err  output  1  sticky: frame_start arrived while a word was partially assembled.
REQ-014 clr_flags  input  1  synchronous clear of overrun and frame_err.

Function
REQ-015 FSM states SHIFT and IDLE only; reset state IDLE.
REQ-016 IDLE: ser_en=1 and frame_start=1 -> bit stored at position 0 of the shift register, bit count = 1, go to SHIFT; ser_en=1 with frame_start=0 -> bit discarded, stay IDLE.
REQ-017 SHIFT: ser_en=1 and frame_start=0 -> bit appended, count +1; ser_en=0 -> hold everything (no timeout).
REQ-018 SHIFT: ser_en=1 and frame_start=1 -> partial word discarded, frame_err set, accepted bit starts a new word (count = 1), stay SHIFT.
REQ-019 Word completes on the cycle its WIDTH-th bit is accepted; next state IDLE; with WIDTH=1 each frame_start bit completes a word directly from IDLE.
REQ-020 Completed word is written to par_out, par_valid=1, on the clk edge that accepts the final bit (visible the following cycle); one-cycle latency from final bit strobe.
REQ-021 Buffer free for write = par_valid=0, or par_valid=1 and par_ready=1 in the same cycle (back-to-back words with no bubble).
REQ-022 Buffer not free at completion -> word dropped, par_out/par_valid unchanged, overrun set.
REQ-023 par_valid clears on transfer unless a new word is written in the same cycle (REQ-021), in which case it stays 1 with new data.
REQ-024 Shift register and output buffer are separate: the next word shifts in while par_out is held.
REQ-025 Bit count width = clog2(WIDTH+1); count never exceeds WIDTH.
REQ-026 clr_flags and a set condition in the same cycle -> flag ends 1 (set wins).
REQ-027 par_ready when par_valid=0 has no effect.

Reset
REQ-028 reset_n low asynchronously forces: state IDLE, count 0, shift register 0, par_out 0, par_valid 0, busy 0, overrun 0, frame_err 0.
REQ-029 Reset mid-word discards the partial word; first bit after release requires frame_start.
REQ-030 All outputs driven by registers; no combinational path from inputs to outputs.

Structure
REQ-031 Shared package holds the FSM state encoding (IDLE=0, SHIFT=1) and the bit-order constants MSB_FIRST / LSB_FIRST.
REQ-032 One sub-module, shift_deser_obuf: single-entry valid/ready output register implementing REQ-020..REQ-023 and REQ-027.

Verification
REQ-033 WIDTH=4, MSB_FIRST=1: bits 1,0,1,1 (frame_start on first), par_ready=1 -> par_out=4'b1011, par_valid high exactly 1 cycle, one cycle after 4th strobe.
REQ-034 WIDTH=4, MSB_FIRST=0: same bits 1,0,1,1 -> par_out=4'b1101.
REQ-035 par_ready=0, send 4'hA then 4'h5 -> par_out stays 4'hA, overrun=1; then clr_flags pulse -> overrun=0.
REQ-036 Send 2 bits, then frame_start with bits 0,1,1,0 -> frame_err=1, par_out=4'b0110, single par_valid.
REQ-037 Continuous ser_en every cycle, par_ready=1, words 4'h3, 4'hC, 4'hF -> three valids 4 cycles apart, no overrun.
REQ-038 reset_n pulsed low after 3 bits -> all outputs 0; next 4 bits without frame_start ignored; par_valid stays 0.
